// File: rtl/imem_write_sched_if.sv
// imem_write_sched_if: core / loader / instruction-memory signal bundle (IMEM_LOAD_CHKSUM_EN adds ldr_chksum)
interface imem_write_sched_if #(
    parameter int PC_WIDTH = 8,
    parameter int DATA_W   = 16
);
    logic                core_we;
    logic [PC_WIDTH-1:0] core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic                ldr_start;
    logic                ldr_valid;
    logic                ldr_ready;
    logic [DATA_W-1:0]   ldr_data;
    logic                ldr_last;
    logic [PC_WIDTH-1:0] ldr_base;
    logic                imem_we;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [DATA_W-1:0]   imem_wdata;
    logic                core_stall;
    logic                load_done;
    logic                load_err;
`ifdef IMEM_LOAD_CHKSUM_EN
    logic [DATA_W-1:0]   ldr_chksum;

    modport master (
        output core_we, core_addr, core_wdata, ldr_start, ldr_valid, ldr_data, ldr_last, ldr_base,
        input  ldr_ready, imem_we, imem_addr, imem_wdata, core_stall, load_done, load_err, ldr_chksum
    );

    modport slave (
        input  core_we, core_addr, core_wdata, ldr_start, ldr_valid, ldr_data, ldr_last, ldr_base,
        output ldr_ready, imem_we, imem_addr, imem_wdata, core_stall, load_done, load_err, ldr_chksum
    );
`else
    modport master (
        output core_we, core_addr, core_wdata, ldr_start, ldr_valid, ldr_data, ldr_last, ldr_base,
        input  ldr_ready, imem_we, imem_addr, imem_wdata, core_stall, load_done, load_err
    );

    modport slave (
        input  core_we, core_addr, core_wdata, ldr_start, ldr_valid, ldr_data, ldr_last, ldr_base,
        output ldr_ready, imem_we, imem_addr, imem_wdata, core_stall, load_done, load_err
    );
`endif
endinterface

// File: rtl/imem_write_sched.sv
// imem_write_sched: arbitrates the imem write port between core self-modify writes and a loader burst (IMEM_LOAD_CHKSUM_EN adds a burst XOR checksum)
module imem_write_sched #(
    parameter int PC_WIDTH  = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 256
) (
    input  logic               clk,
    input  logic               irst_done_reg,
    imem_write_sched_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);

    logic [1:0]          r_state;
    logic [PC_WIDTH-1:0] r_ptr;
    logic [CW-1:0]       r_cnt;
    logic                r_pend_v;
    logic [PC_WIDTH-1:0] r_pend_addr;
    logic [DATA_W-1:0]   r_pend_data;
    logic                r_imem_we;
    logic [PC_WIDTH-1:0] r_imem_addr;
    logic [DATA_W-1:0]   r_imem_wdata;
    logic                r_ldr_ready;
    logic                r_core_stall;
    logic                r_load_done;
    logic                r_load_err;
    logic                w_hs;
    logic                w_cap;
    logic                w_final;
    logic                w_ovf;

    assign w_hs    = r_ldr_ready & bus.ldr_valid;
    assign w_cap   = r_cnt == LAST_CNT;
    assign w_final = w_hs & (bus.ldr_last | w_cap);
    assign w_ovf   = w_hs & ~bus.ldr_last & w_cap;

    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.ldr_ready  = r_ldr_ready;
    assign bus.core_stall = r_core_stall;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;

    // Scheduler FSM: core writes pass through in RUN, loader owns the port in LOAD, a parked core write drains in FLUSH
    always_ff @(posedge clk or posedge irst_done_reg) begin
        if (irst_done_reg) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_pend_v     <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_ldr_ready  <= 1'b0;
            r_core_stall <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_imem_we   <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_RUN;
                S_RUN: begin
                    if (bus.ldr_start) begin
                        r_state      <= S_LOAD;
                        r_ptr        <= bus.ldr_base;
                        r_cnt        <= '0;
                        r_core_stall <= 1'b1;
                        r_ldr_ready  <= 1'b1;
                        if (bus.core_we) begin
                            r_pend_v    <= 1'b1;
                            r_pend_addr <= bus.core_addr;
                            r_pend_data <= bus.core_wdata;
                        end
                    end else if (bus.core_we) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= bus.core_addr;
                        r_imem_wdata <= bus.core_wdata;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_ptr;
                        r_imem_wdata <= bus.ldr_data;
                        r_ptr        <= r_ptr + 1'b1;
                        r_cnt        <= r_cnt + 1'b1;
                    end
                    if (w_final) begin
                        r_ldr_ready <= 1'b0;
                        r_load_done <= 1'b1;
                        r_state     <= S_FLUSH;
                    end
                    if (w_ovf)
                        r_load_err <= 1'b1;
                    if (bus.core_we && !r_pend_v) begin
                        r_pend_v    <= 1'b1;
                        r_pend_addr <= bus.core_addr;
                        r_pend_data <= bus.core_wdata;
                    end else if (bus.core_we)
                        r_load_err <= 1'b1;
                end
                S_FLUSH: begin
                    if (r_pend_v) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_pend_addr;
                        r_imem_wdata <= r_pend_data;
                        r_pend_v     <= 1'b0;
                    end else begin
                        r_core_stall <= 1'b0;
                        r_state      <= S_RUN;
                    end
                end
            endcase
        end
    end

`ifdef IMEM_LOAD_CHKSUM_EN
    logic [DATA_W-1:0] r_chksum;

    assign bus.ldr_chksum = r_chksum;

    // Running XOR of accepted loader words, restarted by each accepted ldr_start
    always_ff @(posedge clk or posedge irst_done_reg) begin
        if (irst_done_reg)
            r_chksum <= '0;
        else if (r_state == S_RUN && bus.ldr_start)
            r_chksum <= '0;
        else if (r_state == S_LOAD && w_hs)
            r_chksum <= r_chksum ^ bus.ldr_data;
    end
`else
    // Checksum port and logic are absent in this build
`endif
endmodule

// File: tb/tb_imem_write_sched.sv
// tb_imem_write_sched: directed self-checking bench for imem_write_sched (built with MAX_WORDS=4)
module tb_imem_write_sched;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic irst_done_reg = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] words [8];

    imem_write_sched_if #(.PC_WIDTH(8), .DATA_W(16)) bus ();

    imem_write_sched #(.PC_WIDTH(8), .DATA_W(16), .MAX_WORDS(MAXW)) dut (
        .clk           (clk),
        .irst_done_reg (irst_done_reg),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] base, input logic cw, input logic [7:0] ca, input logic [15:0] cd);
        bus.ldr_start  = 1'b1;
        bus.ldr_base   = base;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        tick();
        bus.ldr_start = 1'b0;
        bus.core_we   = 1'b0;
        check("start_stall", bus.core_stall, 1);
        check("start_ready", bus.ldr_ready, 1);
        check("start_we", bus.imem_we, 0);
        check("start_done", bus.load_done, 0);
    endtask

    task automatic stream(input logic [7:0] base, input int n, input int nlast);
        bit done = 0;
        bit fin;
        for (int i = 0; i < n; i++) begin
            bus.ldr_valid = 1'b1;
            bus.ldr_data  = words[i];
            bus.ldr_last  = (i == nlast - 1);
            tick();
            if (!done) begin
                fin = (i == nlast - 1) || (i == MAXW - 1);
                check("ld_we", bus.imem_we, 1);
                check("ld_addr", bus.imem_addr, 32'(8'(base + 8'(i))));
                check("ld_data", bus.imem_wdata, words[i]);
                check("ld_done", bus.load_done, fin);
                check("ld_ready", bus.ldr_ready, !fin);
                check("ld_stall", bus.core_stall, 1);
                done = fin;
            end else begin
                check("late_we", bus.imem_we, 0);
                check("late_ready", bus.ldr_ready, 0);
            end
        end
        bus.ldr_valid = 1'b0;
        bus.ldr_last  = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"}, bus.imem_we, 0);
        check({tag, "_stall"}, bus.core_stall, 0);
        check({tag, "_done"}, bus.load_done, 0);
        check({tag, "_ready"}, bus.ldr_ready, 0);
    endtask

    initial begin
        bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        bus.ldr_start = 0; bus.ldr_valid = 0; bus.ldr_data = 0;
        bus.ldr_last = 0; bus.ldr_base = 0;
        tick();
        tick();
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_data", bus.imem_wdata, 0);
        check("rst_ready", bus.ldr_ready, 0);
        check("rst_stall", bus.core_stall, 0);
        check("rst_done", bus.load_done, 0);
        check("rst_err", bus.load_err, 0);
        irst_done_reg = 1'b0;
        tick();

        // core write passes through with one cycle latency
        bus.core_we = 1; bus.core_addr = 8'd5; bus.core_wdata = 16'hA5A5;
        tick();
        bus.core_we = 0;
        check("cw_we", bus.imem_we, 1);
        check("cw_addr", bus.imem_addr, 5);
        check("cw_data", bus.imem_wdata, 16'hA5A5);
        check("cw_stall", bus.core_stall, 0);
        bus.ldr_valid = 1;
        tick();
        bus.ldr_valid = 0;
        check_quiet("run_valid");

        // plain 4-word load at 128
        for (int i = 0; i < 4; i++) words[i] = 16'(i + 1);
        start_load(8'd128, 0, 8'd0, 16'h0);
        stream(8'd128, 4, 4);
        tick();
        check_quiet("l1_end");
        check("l1_err", bus.load_err, 0);

        // colliding core write is parked and issued after load_done
        for (int i = 0; i < 4; i++) words[i] = 16'(16'h10 + i);
        start_load(8'd128, 1, 8'd129, 16'hBEEF);
        stream(8'd128, 4, 4);
        tick();
        check("fl_we", bus.imem_we, 1);
        check("fl_addr", bus.imem_addr, 129);
        check("fl_data", bus.imem_wdata, 16'hBEEF);
        check("fl_stall", bus.core_stall, 1);
        check("fl_done", bus.load_done, 0);
        tick();
        check_quiet("fl_end");

        // address wrap 254,255,0,1
        for (int i = 0; i < 4; i++) words[i] = 16'(16'h20 + i);
        start_load(8'd254, 0, 8'd0, 16'h0);
        stream(8'd254, 4, 4);
        check("wrap_err", bus.load_err, 0);
        tick();
        check_quiet("wrap_end");

        // checksum burst
        words[0] = 16'h1234; words[1] = 16'h00FF; words[2] = 16'hF0F0;
        start_load(8'd16, 0, 8'd0, 16'h0);
        stream(8'd16, 3, 3);
`ifdef IMEM_LOAD_CHKSUM_EN
        check("chksum", bus.ldr_chksum, 16'hE23B);
`endif
        tick();
        check_quiet("ck_end");
        check("ck_err", bus.load_err, 0);

        // overflow: 5 words, no last, MAX_WORDS=4
        for (int i = 0; i < 5; i++) words[i] = 16'(16'h40 + i);
        start_load(8'd64, 0, 8'd0, 16'h0);
        stream(8'd64, 5, 0);
        check("ovf_err", bus.load_err, 1);
        check("ovf_stall", bus.core_stall, 0);
        tick();
        check("ovf_err_sticky", bus.load_err, 1);

        // reset mid-burst clears outputs immediately
        for (int i = 0; i < 4; i++) words[i] = 16'(16'h50 + i);
        start_load(8'd8, 0, 8'd0, 16'h0);
        bus.ldr_valid = 1; bus.ldr_data = words[0];
        tick();
        check("mid_we", bus.imem_we, 1);
        irst_done_reg = 1'b1;
        #1;
        check("mrst_we", bus.imem_we, 0);
        check("mrst_addr", bus.imem_addr, 0);
        check("mrst_data", bus.imem_wdata, 0);
        check("mrst_ready", bus.ldr_ready, 0);
        check("mrst_stall", bus.core_stall, 0);
        check("mrst_err", bus.load_err, 0);
        bus.ldr_valid = 0;
        tick();
        irst_done_reg = 1'b0;
        tick();
        tick();
        check_quiet("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_write_sched.md
Name: imem_write_sched

Overview:
- Schedules the single instruction-memory write port between two requesters:
  - the core's self-modify path (inst_write_en / inst_write_data at pc);
  - a program loader stream, used to swap program images after the irst phase.
- Sits between mips_16_core_top, the loader and instruction_mem.
- Stalls the core while an image is being reloaded.
- Buffers one colliding core write.

Parameters:
- PC_WIDTH, 8, instruction-memory address width.
- DATA_W, 16, instruction word width.
- MAX_WORDS, 256, maximum words accepted per load burst; must be ≤ 2^PC_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- irst_done_reg  in  1  reset, asynchronous, active-high.
- core_we  in  1  core instruction-write request.
- core_addr  in  PC_WIDTH  core write address (pc).
- core_wdata  in  DATA_W  core write data.
- ldr_start  in  1  single-cycle pulse; begins a load burst.
- ldr_valid  in  1  loader word valid.
- ldr_ready  out  1  loader word accepted when valid && ready.
- ldr_data  in  DATA_W  loader word.
- ldr_last  in  1  marks final word of the burst.
- ldr_base  in  PC_WIDTH  start address, sampled on ldr_start.
- imem_we  out  1  write enable to instruction_mem.
- imem_addr  out  PC_WIDTH  write address.
- imem_wdata  out  DATA_W  write data.
- core_stall  out  1  holds core pc / pipeline.
- load_done  out  1  one-cycle pulse at end of burst.
- load_err  out  1  sticky overflow flag.

Behaviour:
- Reset values (all outputs 0, state IDLE):
  - imem_we, imem_addr, imem_wdata, ldr_ready, core_stall, load_done, load_err = 0.
  - Pending buffer empty; word counter 0.
- All outputs are registered. Write latency is 1 cycle from the accepted request to imem_we.
- FSM states: IDLE, RUN, LOAD, FLUSH.
- IDLE:
  - Entered from reset. Moves to RUN on the next cycle.
- RUN:
  - core_we=1 → imem_we=1, imem_addr=core_addr, imem_wdata=core_wdata next cycle.
  - ldr_start=1 → LOAD: addr_ptr=ldr_base, counter=0, core_stall=1.
  - ldr_start and core_we in the same cycle: the core write is captured into the pending buffer, then LOAD is entered.
- LOAD:
  - ldr_ready=1 and core_stall=1.
  - Each handshake writes ldr_data to addr_ptr. addr_ptr increments modulo 2^PC_WIDTH (wraps to 0); counter increments.
  - core_we during LOAD:
    - Pending buffer empty → write is captured.
    - Pending buffer full → write is dropped and load_err is set. Unreachable while the core honours core_stall.
  - Handshake with ldr_last=1, or counter reaching MAX_WORDS:
    - Drop ldr_ready.
    - Pulse load_done the cycle after the final write.
    - Go to FLUSH.
  - counter==MAX_WORDS without ldr_last → load_err=1.
  - load_err is sticky until reset.
- FLUSH:
  - Pending buffer full → issue it as one imem write.
  - Then clear core_stall and return to RUN (1 cycle if the buffer is empty, 2 cycles if full).
  - The pending core write is deliberately issued after the load, so it overrides loader data at the same address.
- ldr_start while in LOAD or FLUSH is ignored.
- ldr_valid outside LOAD is ignored; ldr_ready stays 0.
- Reset asserted mid-burst:
  - Immediate return to IDLE; outputs cleared.
  - Partial image stays in memory; the pending buffer is discarded.

Optional Feature:
- Macro IMEM_LOAD_CHKSUM_EN.
- Defined:
  - Adds output ldr_chksum [DATA_W-1:0].
  - Running XOR of every accepted loader word in the burst; cleared on ldr_start.
  - Valid and stable from the load_done pulse until the next ldr_start.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then core_we=1, core_addr=5, core_wdata=0xA5A5 → one cycle later imem_we=1, addr 5, data 0xA5A5; core_stall=0.
- ldr_start, ldr_base=128, stream 4 words 0x0001..0x0004 with last on the 4th:
  - writes to 128..131 in order;
  - load_done pulses once;
  - core_stall lasts from the cycle after start to 1 cycle after load_done.
- ldr_start and core_we (addr 129, 0xBEEF) in the same cycle, then a 4-word load at 128 → final imem write is addr 129 / 0xBEEF, issued in FLUSH after load_done.
- ldr_base=254 (PC_WIDTH=8), 4 words → addresses 254, 255, 0, 1; load_err=0.
- MAX_WORDS=4, stream 5 words without last → 4 writes, load_done pulses, load_err=1 and remains set; 5th word gets ldr_ready=0.
- IMEM_LOAD_CHKSUM_EN defined, words 0x1234, 0x00FF, 0xF0F0 → ldr_chksum=0xE23B at load_done. Reset asserted during a burst → all outputs 0 within the same cycle.
